spi_xfer_buffer: RTL and testbench

- Byte-buffering front end that sits directly upstream and downstream of SpiMaster.
- The host queues TX bytes and transfer commands; this block issues the start pulse, ss_mask and trans_len, and serves the master's per-byte read strobe.
- Each received byte (valid strobe) is captured into an RX FIFO for the host to drain.
- Transfers are launched only when every TX byte is present and RX space is guaranteed.

---
 rtl/spi_buf_pkg.sv | 18 +
 rtl/spi_xfer_buffer_fifo.sv | 57 +++++
 rtl/spi_xfer_buffer.sv | 169 ++++++++++++++++
 tb/tb_spi_xfer_buffer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_buf_pkg.sv
// Shared types and default sizes for the SPI transfer buffer.
package spi_buf_pkg;

    localparam int DEF_DEPTH = 16;
    localparam int DEF_SS_W  = 24;
    localparam int DEF_LEN_W = 8;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        START,
        WAIT_BUSY,
        RUN
    } state_e;

endpackage

// File: rtl/spi_xfer_buffer_fifo.sv
// Show-ahead synchronous FIFO with occupancy output.
// A pop in the same cycle as a push at full frees the slot, so both succeed.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    // Storage; contents are don't-care until written, pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign dout  = r_mem[r_rd];
    assign full  = (r_cnt == (AW+1)'(DEPTH));
    assign empty = (r_cnt == '0);
    assign level = r_cnt;

endmodule

// File: rtl/spi_xfer_buffer.sv
// Byte-buffering front end for SpiMaster: queues TX bytes and commands,
// launches a transfer only when all TX bytes are present and RX space is
// guaranteed, serves the master's read strobe and captures RX bytes.
module spi_xfer_buffer
    import spi_buf_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int SS_W  = DEF_SS_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [SS_W-1:0]        cmd_ss_mask,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic [7:0]             tx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [7:0]             rx_data,
    output logic [$clog2(DEPTH):0] tx_level,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic                   busy,
    input  logic                   clr_flags,
    output logic                   tx_underflow,
    output logic                   rx_overflow,
    output logic                   m_start,
    output logic [SS_W-1:0]        m_ss_mask,
    output logic [LEN_W-1:0]       m_trans_len,
    input  logic                   m_read,
    output logic [7:0]             m_tx_data,
    input  logic                   m_valid,
    input  logic [7:0]             m_rx_data,
    input  logic                   m_busy
);

    state_e           r_state;
    state_e           w_next;
    logic [SS_W-1:0]  r_mask;
    logic [LEN_W-1:0] r_len;
    logic [SS_W-1:0]  r_m_mask;
    logic [LEN_W-1:0] r_m_len;
    byte_t            r_m_tx_data;
    logic             r_txu;
    logic             r_rxo;

    byte_t            w_tx_head;
    logic             w_tx_full;
    logic             w_tx_empty;
    logic             w_rx_full;
    logic             w_rx_empty;
    logic             w_cmd_fire;
    logic [31:0]      w_need;
    logic             w_launch_ok;

    sync_fifo #(.W(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid),
        .din   (tx_data),
        .pop   (m_read),
        .dout  (w_tx_head),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .level (tx_level)
    );

    sync_fifo #(.W(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (m_valid),
        .din   (m_rx_data),
        .pop   (rx_ready),
        .dout  (rx_data),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .level (rx_level)
    );

    assign tx_ready   = ~w_tx_full;
    assign rx_valid   = ~w_rx_empty;
    assign w_cmd_fire = cmd_valid & cmd_ready;

    // Compare in 32 bits so len+1 cannot wrap against the level width.
    assign w_need      = 32'(r_len) + 32'd1;
    assign w_launch_ok = (32'(tx_level) >= w_need) &&
                         ((32'(DEPTH) - 32'(rx_level)) >= w_need);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        m_start   = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) w_next = CHECK;
            end
            CHECK:     if (w_launch_ok) w_next = START;
            START: begin
                m_start = 1'b1;
                w_next  = WAIT_BUSY;
            end
            WAIT_BUSY: if (m_busy)  w_next = RUN;
            RUN:       if (!m_busy) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Command latch, and the copy presented to the master from START onwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask   <= '0;
            r_len    <= '0;
            r_m_mask <= '0;
            r_m_len  <= '0;
        end else begin
            if (w_cmd_fire) begin
                r_mask <= cmd_ss_mask;
                r_len  <= cmd_len;
            end
            if (r_state == CHECK && w_next == START) begin
                r_m_mask <= r_mask;
                r_m_len  <= r_len;
            end
        end
    end

    // Serve TX head to the master; an empty FIFO yields zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_m_tx_data <= '0;
        else if (m_read) r_m_tx_data <= w_tx_empty ? 8'h00 : w_tx_head;
    end

    // Sticky error flags; clear wins over a same-cycle set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_txu <= 1'b0;
            r_rxo <= 1'b0;
        end else if (clr_flags) begin
            r_txu <= 1'b0;
            r_rxo <= 1'b0;
        end else begin
            if (m_read && w_tx_empty)              r_txu <= 1'b1;
            if (m_valid && w_rx_full && !rx_ready) r_rxo <= 1'b1;
        end
    end

    assign m_ss_mask    = r_m_mask;
    assign m_trans_len  = r_m_len;
    assign m_tx_data    = r_m_tx_data;
    assign tx_underflow = r_txu;
    assign rx_overflow  = r_rxo;

    // A command longer than the FIFO depth would stall in CHECK forever.
    a_len_fits: assert property (@(posedge clk) disable iff (!rst)
        w_cmd_fire |-> (32'(cmd_len) + 32'd1 <= 32'(DEPTH)));

endmodule

// File: tb/tb_spi_xfer_buffer.sv
// Directed bench for spi_xfer_buffer: a per-cycle datapath vector table plus
// hand-written sequences for the command FSM corner cases.
module tb_spi_xfer_buffer;

    localparam int DEPTH = 16;
    localparam int SS_W  = 24;
    localparam int LEN_W = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [SS_W-1:0]        cmd_ss_mask;
    logic [LEN_W-1:0]       cmd_len;
    logic                   tx_valid;
    logic                   tx_ready;
    logic [7:0]             tx_data;
    logic                   rx_valid;
    logic                   rx_ready;
    logic [7:0]             rx_data;
    logic [$clog2(DEPTH):0] tx_level;
    logic [$clog2(DEPTH):0] rx_level;
    logic                   busy;
    logic                   clr_flags;
    logic                   tx_underflow;
    logic                   rx_overflow;
    logic                   m_start;
    logic [SS_W-1:0]        m_ss_mask;
    logic [LEN_W-1:0]       m_trans_len;
    logic                   m_read;
    logic [7:0]             m_tx_data;
    logic                   m_valid;
    logic [7:0]             m_rx_data;
    logic                   m_busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    spi_xfer_buffer #(.DEPTH(DEPTH), .SS_W(SS_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ss_mask(cmd_ss_mask), .cmd_len(cmd_len),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .tx_level(tx_level), .rx_level(rx_level), .busy(busy),
        .clr_flags(clr_flags), .tx_underflow(tx_underflow), .rx_overflow(rx_overflow),
        .m_start(m_start), .m_ss_mask(m_ss_mask), .m_trans_len(m_trans_len),
        .m_read(m_read), .m_tx_data(m_tx_data),
        .m_valid(m_valid), .m_rx_data(m_rx_data), .m_busy(m_busy)
    );

    typedef struct {
        logic       tx_valid;
        logic [7:0] tx_data;
        logic       m_read;
        logic       m_valid;
        logic [7:0] m_rx_data;
        logic       rx_ready;
        logic       clr;
        int         exp_txl;
        int         exp_rxl;
        logic [7:0] exp_mtx;
        logic [7:0] exp_rxd;
        logic       exp_txu;
        logic       exp_rxo;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_ss_mask = '0; cmd_len = '0;
        tx_valid = 0; tx_data = '0; rx_ready = 0; clr_flags = 0;
        m_read = 0; m_valid = 0; m_rx_data = '0; m_busy = 0;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic wait_start(input int max, input string name);
        int k = 0;
        while (!m_start && k < max) begin
            step();
            k++;
        end
        chk(name, m_start, 1);
    endtask

    initial begin
        // Datapath-only vectors: each row is one clock, FSM stays IDLE.
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2, 0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1, 0, 8'h11, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1, 0, 8'h22, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1, 1, 8'h22, 8'h3C, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h4D, 1'b1, 1'b0, 1, 1, 8'h22, 8'h4D, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1, 8'h33, 8'h4D, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1, 8'h00, 8'h4D, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1, 8'h00, 8'h4D, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1, 8'h00, 8'h4D, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 8'h00, 8'h00, 1'b0, 1'b0};

        // Reset state
        do_reset();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_start", m_start, 0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_m_tx_data", m_tx_data, 0);
        chk("rst_m_ss_mask", m_ss_mask, 0);
        chk("rst_m_trans_len", m_trans_len, 0);
        chk("rst_txu", tx_underflow, 0);
        chk("rst_rxo", rx_overflow, 0);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            tx_valid = vecs[i].tx_valid; tx_data = vecs[i].tx_data;
            m_read = vecs[i].m_read; m_valid = vecs[i].m_valid;
            m_rx_data = vecs[i].m_rx_data; rx_ready = vecs[i].rx_ready;
            clr_flags = vecs[i].clr;
            step();
            chk($sformatf("vec%0d_tx_level", i), tx_level, vecs[i].exp_txl);
            chk($sformatf("vec%0d_rx_level", i), rx_level, vecs[i].exp_rxl);
            chk($sformatf("vec%0d_m_tx_data", i), m_tx_data, vecs[i].exp_mtx);
            chk($sformatf("vec%0d_txu", i), tx_underflow, vecs[i].exp_txu);
            chk($sformatf("vec%0d_rxo", i), rx_overflow, vecs[i].exp_rxo);
            if (vecs[i].exp_rxl != 0) chk($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp_rxd);
        end
        idle_inputs();

        // Single-byte transfer
        do_reset();
        tx_valid = 1; tx_data = 8'hA5; step(); tx_valid = 0;
        chk("A_tx_level", tx_level, 1);
        cmd_valid = 1; cmd_ss_mask = 24'h8; cmd_len = 0; step(); cmd_valid = 0;
        chk("A_check_no_start", m_start, 0);
        chk("A_check_busy", busy, 1);
        chk("A_check_cmd_ready", cmd_ready, 0);
        step();
        chk("A_start", m_start, 1);
        chk("A_mask", m_ss_mask, 24'h8);
        chk("A_len", m_trans_len, 0);
        step();
        chk("A_start_one_cycle", m_start, 0);
        m_busy = 1; m_read = 1; step(); m_read = 0;
        chk("A_m_tx_data", m_tx_data, 8'hA5);
        chk("A_tx_level_after", tx_level, 0);
        m_valid = 1; m_rx_data = 8'h3C; step(); m_valid = 0;
        chk("A_rx_valid", rx_valid, 1);
        chk("A_rx_data", rx_data, 8'h3C);
        chk("A_rx_level", rx_level, 1);
        chk("A_mask_held", m_ss_mask, 24'h8);
        chk("A_busy_run", busy, 1);
        m_busy = 0; step();
        chk("A_idle_busy", busy, 0);
        chk("A_idle_cmd_ready", cmd_ready, 1);

        // Launch waits for all TX bytes
        do_reset();
        tx_valid = 1; tx_data = 8'hFF; step(); tx_data = 8'h33; step(); tx_valid = 0;
        cmd_valid = 1; cmd_ss_mask = 24'h1; cmd_len = 3; step(); cmd_valid = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("B_stall_no_start", m_start, 0);
            chk("B_stall_busy", busy, 1);
        end
        tx_valid = 1; tx_data = 8'hAA; step(); tx_data = 8'h55; step(); tx_valid = 0;
        chk("B_no_start_yet", m_start, 0);
        step();
        chk("B_start", m_start, 1);
        chk("B_len", m_trans_len, 3);
        m_busy = 1; step(); step();
        m_read = 1;
        step(); chk("B_rd0", m_tx_data, 8'hFF);
        step(); chk("B_rd1", m_tx_data, 8'h33);
        step(); chk("B_rd2", m_tx_data, 8'hAA);
        step(); chk("B_rd3", m_tx_data, 8'h55);
        m_read = 0;
        chk("B_tx_level", tx_level, 0);
        chk("B_no_underflow", tx_underflow, 0);
        m_busy = 0; step();
        chk("B_idle", busy, 0);

        // Launch waits for RX space
        do_reset();
        m_valid = 1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            m_rx_data = 8'(i); step();
        end
        m_valid = 0;
        chk("C_rx_level", rx_level, DEPTH - 1);
        tx_valid = 1; tx_data = 8'h01; step(); tx_data = 8'h02; step(); tx_valid = 0;
        cmd_valid = 1; cmd_ss_mask = 24'h2; cmd_len = 1; step(); cmd_valid = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("C_stall_no_start", m_start, 0);
        end
        rx_ready = 1; step(); rx_ready = 0;
        chk("C_rx_level_pop", rx_level, DEPTH - 2);
        chk("C_rx_head", rx_data, 8'h01);
        wait_start(4, "C_start_seen");
        chk("C_len", m_trans_len, 1);
        chk("C_no_overflow", rx_overflow, 0);

        // Sticky flags and clear priority
        do_reset();
        tx_valid = 1; tx_data = 8'h77; step(); tx_valid = 0;
        m_read = 1; step();
        chk("D_rd", m_tx_data, 8'h77);
        chk("D_no_txu", tx_underflow, 0);
        step();
        chk("D_empty_rd_data", m_tx_data, 8'h00);
        chk("D_txu_set", tx_underflow, 1);
        clr_flags = 1; step(); clr_flags = 0; m_read = 0;
        chk("D_clr_priority_txu", tx_underflow, 0);
        m_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            m_rx_data = 8'(8'h40 + i); step();
        end
        chk("D_rx_full_level", rx_level, DEPTH);
        chk("D_rxo_not_yet", rx_overflow, 0);
        m_rx_data = 8'hEE; step();
        chk("D_rxo_set", rx_overflow, 1);
        chk("D_rx_level_held", rx_level, DEPTH);
        chk("D_rx_head_kept", rx_data, 8'h40);
        clr_flags = 1; step(); clr_flags = 0; m_valid = 0;
        chk("D_clr_priority_rxo", rx_overflow, 0);

        // Full TX FIFO with simultaneous push and pop
        do_reset();
        tx_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            tx_data = 8'(8'h80 + i); step();
        end
        chk("E_full_level", tx_level, DEPTH);
        chk("E_tx_ready_full", tx_ready, 0);
        tx_data = 8'hEE; m_read = 1; step(); tx_valid = 0;
        chk("E_pushpop_data", m_tx_data, 8'h80);
        chk("E_pushpop_level", tx_level, DEPTH);
        for (int i = 1; i < DEPTH; i++) begin
            step();
            chk($sformatf("E_drain%0d", i), m_tx_data, 8'(8'h80 + i));
        end
        step();
        chk("E_drain_new", m_tx_data, 8'hEE);
        chk("E_empty_level", tx_level, 0);
        m_read = 0;

        // Reset mid-transfer, then a fresh command
        do_reset();
        tx_valid = 1; tx_data = 8'h5A; step(); tx_data = 8'h6B; step(); tx_valid = 0;
        cmd_valid = 1; cmd_ss_mask = 24'h2; cmd_len = 0; step(); cmd_valid = 0;
        wait_start(4, "F_start_seen");
        m_busy = 1; step();
        m_valid = 1; m_rx_data = 8'h99; step(); m_valid = 0;
        chk("F_run_busy", busy, 1);
        chk("F_run_rx_level", rx_level, 1);
        #2 rst = 0;
        #1;
        chk("F_rst_busy", busy, 0);
        chk("F_rst_tx_level", tx_level, 0);
        chk("F_rst_rx_level", rx_level, 0);
        chk("F_rst_m_start", m_start, 0);
        chk("F_rst_mask", m_ss_mask, 0);
        chk("F_rst_cmd_ready", cmd_ready, 1);
        m_busy = 0;
        #2 rst = 1;
        tx_valid = 1; tx_data = 8'hC3; step(); tx_valid = 0;
        cmd_valid = 1; cmd_ss_mask = 24'h4; cmd_len = 0; step(); cmd_valid = 0;
        wait_start(4, "F_restart_seen");
        chk("F_restart_mask", m_ss_mask, 24'h4);
        step();
        m_read = 1; step(); m_read = 0;
        chk("F_restart_data", m_tx_data, 8'hC3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
